// File: rtl/led_fader_if.sv
// led_fader port bundle: target pattern and enable in,
// PWM drive and busy flag out.
interface led_fader_if #(
  parameter int NUM_LEDS = 16
);
  logic [NUM_LEDS-1:0] pattern_in;
  logic                en;
  logic [NUM_LEDS-1:0] ledr_out;
  logic                busy;

  modport master (
    output pattern_in,
    output en,
    input  ledr_out,
    input  busy
  );

  modport slave (
    input  pattern_in,
    input  en,
    output ledr_out,
    output busy
  );
endinterface

// File: rtl/led_fader.sv
// Per-LED PWM fader with saturating ramp/decay on a divided tick.
// Define LED_FADER_GAMMA_EN for squared (perceptual) duty mapping.
module led_fader #(
  parameter int NUM_LEDS  = 16,
  parameter int PWM_BITS  = 8,
  parameter int STEP_DIV  = 1024,
  parameter int FADE_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  led_fader_if.slave bus
);

  localparam int MAX = (1 << PWM_BITS) - 1;
  localparam int SW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] LP_MAX =
    PWM_BITS'(MAX);
  localparam logic [PWM_BITS-1:0] LP_PWM_TOP =
    PWM_BITS'(MAX - 1);
  localparam logic [SW-1:0] LP_STEP_TOP =
    SW'(STEP_DIV - 1);
  localparam logic [PWM_BITS:0] LP_FADE =
    (PWM_BITS + 1)'(FADE_STEP);
  localparam logic [PWM_BITS:0] LP_MAX_W =
    (PWM_BITS + 1)'(MAX);

  logic [PWM_BITS-1:0] r_level [NUM_LEDS];
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [SW-1:0]       r_step_cnt;
  logic [NUM_LEDS-1:0] r_ledr;

  logic                w_step_tick;
  logic [PWM_BITS-1:0] w_next [NUM_LEDS];
  logic [PWM_BITS-1:0] w_duty [NUM_LEDS];
  logic [NUM_LEDS-1:0] w_pwm_hi;
  logic [NUM_LEDS-1:0] w_off_tgt;

  assign w_step_tick =
    bus.en && (r_step_cnt == LP_STEP_TOP);

  // Saturating step toward the target rail, one bit of headroom.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      logic [PWM_BITS:0] v_lvl;
      logic [PWM_BITS:0] v_up;
      v_lvl = {1'b0, r_level[i]};
      v_up  = v_lvl + LP_FADE;
      w_next[i] = r_level[i];
      if (bus.pattern_in[i]) begin
        if (v_up > LP_MAX_W) w_next[i] = LP_MAX;
        else w_next[i] = v_up[PWM_BITS-1:0];
      end else begin
        if (v_lvl < LP_FADE) w_next[i] = '0;
        else w_next[i] = PWM_BITS'(v_lvl - LP_FADE);
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  // Full-on is pinned to MAX so it never flickers.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      logic [2*PWM_BITS-1:0] v_sq;
      v_sq = {{PWM_BITS{1'b0}}, r_level[i]}
           * {{PWM_BITS{1'b0}}, r_level[i]};
      w_duty[i] = PWM_BITS'(v_sq >> PWM_BITS);
      if (r_level[i] == LP_MAX) w_duty[i] = LP_MAX;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_duty[i] = r_level[i];
    end
  end
`endif

  always_comb begin
    w_pwm_hi  = '0;
    w_off_tgt = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_pwm_hi[i] = w_duty[i] > r_pwm_cnt;
      if (bus.pattern_in[i])
        w_off_tgt[i] = r_level[i] != LP_MAX;
      else
        w_off_tgt[i] = r_level[i] != '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt == LP_PWM_TOP) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt <= '0;
    end else if (w_step_tick) begin
      r_step_cnt <= '0;
    end else if (bus.en) begin
      r_step_cnt <= r_step_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (rst) begin
        r_level[i] <= '0;
      end else if (w_step_tick) begin
        r_level[i] <= w_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ledr <= '0;
    end else begin
      r_ledr <= w_pwm_hi;
    end
  end

  assign bus.ledr_out = r_ledr;
  assign bus.busy     = |w_off_tgt;

endmodule

// File: tb/tb_led_fader.sv
// Directed and randomized checks of led_fader against a
// cycle-count reference model (MAX=15, STEP_DIV=4, FADE_STEP=4).
module tb_led_fader;

  localparam int N   = 16;
  localparam int PB  = 4;
  localparam int MAX = 15;
  localparam int SD  = 4;
  localparam int FS  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  led_fader_if #(.NUM_LEDS(N)) bus ();

  led_fader #(
    .NUM_LEDS (N),
    .PWM_BITS (PB),
    .STEP_DIV (SD),
    .FADE_STEP(FS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  int          m_level [N];
  int          m_t;
  int          m_s;
  logic [N-1:0] m_ledr;

  function automatic int duty(input int l);
`ifdef LED_FADER_GAMMA_EN
    if (l == MAX) return MAX;
    return (l * l) >> PB;
`else
    return l;
`endif
  endfunction

  function automatic logic m_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_level[i] != (bus.pattern_in[i] ? MAX : 0))
        b = 1'b1;
    end
    return b;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h at %0t",
             tag, obs, exp, $time);
    end
  endtask

  // Model advances by arithmetic on elapsed/enabled cycle counts.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_level[i] = 0;
      m_t = 0;
      m_s = 0;
      m_ledr = '0;
    end else begin
      logic tick;
      for (int i = 0; i < N; i++)
        m_ledr[i] = duty(m_level[i]) > (m_t % MAX);
      tick = bus.en && ((m_s % SD) == SD - 1);
      if (bus.en) m_s++;
      m_t++;
      if (tick) begin
        for (int i = 0; i < N; i++) begin
          if (bus.pattern_in[i])
            m_level[i] = (m_level[i] + FS > MAX)
                       ? MAX : m_level[i] + FS;
          else
            m_level[i] = (m_level[i] < FS)
                       ? 0 : m_level[i] - FS;
        end
      end
    end
    #1;
    chk("ledr", 32'(bus.ledr_out), 32'(m_ledr));
    chk("busy", 32'(bus.busy), 32'(m_busy()));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wait_lvl(input int lvl);
    int k;
    k = 0;
    while (m_level[0] != lvl && k < 200) begin
      cyc();
      k++;
    end
    chk("wait_lvl_bound", 32'(k < 200), 32'd1);
  endtask

  task automatic count_hi(input string tag,
                          input int exp);
    int hi;
    hi = 0;
    for (int k = 0; k < MAX; k++) begin
      cyc();
      hi += int'(bus.ledr_out[0]);
    end
    chk(tag, 32'(hi), 32'(exp));
  endtask

  initial begin
    bus.pattern_in = 16'hFFFF;
    bus.en = 1'b0;
    rst = 1'b1;
    run(3);
    chk("rst_ledr", 32'(bus.ledr_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd1);

    bus.pattern_in = 16'h0001;
    bus.en = 1'b1;
    run(20);
    chk("ramp_busy", 32'(bus.busy), 32'd0);
    count_hi("full_on", MAX);
    chk("ramp_others", 32'(bus.ledr_out[N-1:1]), 32'd0);

    bus.pattern_in = 16'h0000;
    wait_lvl(7);
    bus.en = 1'b0;
    run(2);
    count_hi("duty7", duty(7));
    bus.en = 1'b1;
    wait_lvl(0);
    run(2);
    chk("decay_off", 32'(bus.ledr_out), 32'd0);

    bus.pattern_in = 16'h0001;
    wait_lvl(8);
    bus.en = 1'b0;
    run(10);
    count_hi("freeze8", duty(8));
    run(15);
    chk("freeze_hold", 32'(m_level[0]), 32'd8);
    bus.en = 1'b1;
    wait_lvl(12);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid", 32'(bus.ledr_out), 32'd0);
    run(2);
    chk("rst_mid2", 32'(bus.ledr_out), 32'd0);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0)
        bus.pattern_in = 16'($urandom);
      bus.en = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 99) == 0;
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
